// File: rtl/rcc_pkg.sv
// Shared constants, FSM encoding and the DTMF character table for the tone classifier.
package rcc_pkg;

    localparam int unsigned MAX_TONES = 8;
    localparam int unsigned IDX_W     = 3;
    localparam int unsigned RUN_W     = 4;
    localparam int unsigned LOW_BASE  = 0;
    localparam int unsigned HIGH_BASE = 8;

    localparam logic [7:0] NO_DIGIT = 8'hff;

    // Row-major DTMF table: index = lo_idx*4 + hi_idx, first character at the MSB end.
    localparam logic [15:0][7:0] DTMF_ASCII = "123A456B789C*0#D";

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN_LO,
        ST_SCAN_HI,
        ST_CHECK,
        ST_DEBOUNCE,
        ST_EMIT
    } state_t;

    function automatic logic [7:0] dtmf_ascii(input logic [3:0] idx);
        return DTMF_ASCII[~idx];
    endfunction

endpackage

// File: rtl/rcc_peak_tracker.sv
// Sequential max/argmax tracker with tie detection; one element per enabled cycle.
module rcc_peak_tracker
    import rcc_pkg::*;
#(
    parameter int unsigned MAG_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_seed,
    input  logic [MAG_W-1:0] i_mag,
    input  logic [IDX_W-1:0] i_idx,
    output logic [MAG_W-1:0] o_max,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_tie
);

    logic [MAG_W-1:0] r_max;
    logic [IDX_W-1:0] r_idx;
    logic             r_tie;
    logic             w_gt;
    logic             w_eq;

    assign w_gt = {1'b0, i_mag} > {1'b0, r_max};
    assign w_eq = (i_mag == r_max);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_max <= '0;
            r_idx <= '0;
            r_tie <= 1'b0;
        end else if (i_en) begin
            if (i_seed || w_gt) begin
                r_max <= i_mag;
                r_idx <= i_idx;
                r_tie <= 1'b0;
            end else if (w_eq) begin
                r_tie <= 1'b1;
            end
        end
    end

    assign o_max = r_max;
    assign o_idx = r_idx;
    assign o_tie = r_tie;

endmodule

// File: rtl/rcc_tone_classifier.sv
// Peak-tone classifier: scans low/high magnitude banks, validates energy and twist,
// debounces across frames and hands digits off on a valid/ready port.
module rcc_tone_classifier
    import rcc_pkg::*;
#(
    parameter int unsigned N_LOW        = 4,
    parameter int unsigned N_HIGH       = 4,
    parameter int unsigned MAG_W        = 16,
    parameter int unsigned FWD_SHIFT    = 2,
    parameter int unsigned REV_SHIFT    = 2,
    parameter int unsigned DIGIT_FRAMES = 2,
    parameter int unsigned QUIET_FRAMES = 1,
    parameter int unsigned ASCII_MAP    = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [3:0]       wr_addr,
    input  logic [MAG_W-1:0] wr_data,
    input  logic [MAG_W-1:0] min_energy,
    input  logic             frame_start,
    output logic             busy,
    output logic             frame_overrun,
    output logic             digit_valid,
    input  logic             digit_ready,
    output logic [7:0]       digit_code,
    output logic             dout_flag,
    output logic             digit_dropped
);

    state_t           r_state;
    state_t           w_next;
    logic [IDX_W-1:0] r_cnt;

    logic [MAG_W-1:0] r_in_lo [MAX_TONES];
    logic [MAG_W-1:0] r_in_hi [MAX_TONES];
    logic [MAG_W-1:0] r_wk_lo [MAX_TONES];
    logic [MAG_W-1:0] r_wk_hi [MAX_TONES];

    logic [MAG_W-1:0] r_lo_max;
    logic [IDX_W-1:0] r_lo_idx;
    logic             r_lo_tie;
    logic [7:0]       r_code;
    logic [7:0]       r_last;
    logic [RUN_W-1:0] r_run;
    logic             r_seen_quiet;

    logic             r_busy;
    logic             r_overrun;
    logic             r_valid;
    logic [7:0]       r_dcode;
    logic             r_flag;
    logic             r_dropped;

    logic             w_start;
    logic             w_wr_lo;
    logic             w_wr_hi;
    logic [IDX_W-1:0] w_lo_off;
    logic [IDX_W-1:0] w_hi_off;
    logic             w_scan_en;
    logic             w_scan_last;
    logic [MAG_W-1:0] w_scan_mag;
    logic [MAG_W-1:0] w_pk_max;
    logic [IDX_W-1:0] w_pk_idx;
    logic             w_pk_tie;
    logic             w_fwd_ok;
    logic             w_rev_ok;
    logic             w_energy_ok;
    logic [7:0]       w_code;
    logic [RUN_W-1:0] w_run_next;
    logic             w_is_quiet;
    logic             w_emit;

    // Input bank address decode; anything outside the two mapped windows is dropped.
    assign w_lo_off = IDX_W'(32'(wr_addr) - LOW_BASE);
    assign w_hi_off = IDX_W'(32'(wr_addr) - HIGH_BASE);
    assign w_wr_lo  = wr_en && (32'(wr_addr) < LOW_BASE + N_LOW);
    assign w_wr_hi  = wr_en && (32'(wr_addr) >= HIGH_BASE) && (32'(wr_addr) < HIGH_BASE + N_HIGH);
    assign w_start  = frame_start && (r_state == ST_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_in_lo <= '{default: '0};
            r_in_hi <= '{default: '0};
            r_wk_lo <= '{default: '0};
            r_wk_hi <= '{default: '0};
        end else begin
            if (w_wr_lo) r_in_lo[w_lo_off] <= wr_data;
            if (w_wr_hi) r_in_hi[w_hi_off] <= wr_data;
            // Snapshot sees the bank before this cycle's write lands.
            if (w_start) begin
                r_wk_lo <= r_in_lo;
                r_wk_hi <= r_in_hi;
            end
        end
    end

    assign w_scan_en   = (r_state == ST_SCAN_LO) || (r_state == ST_SCAN_HI);
    assign w_scan_last = (r_state == ST_SCAN_LO) ? (32'(r_cnt) == N_LOW - 1)
                                                 : (32'(r_cnt) == N_HIGH - 1);
    assign w_scan_mag  = (r_state == ST_SCAN_HI) ? r_wk_hi[r_cnt] : r_wk_lo[r_cnt];

    rcc_peak_tracker #(
        .MAG_W (MAG_W)
    ) u_peak (
        .clk    (clk),
        .rst_n  (reset),
        .i_en   (w_scan_en),
        .i_seed (r_cnt == '0),
        .i_mag  (w_scan_mag),
        .i_idx  (r_cnt),
        .o_max  (w_pk_max),
        .o_idx  (w_pk_idx),
        .o_tie  (w_pk_tie)
    );

    // In CHECK the tracker holds the high-group result; the low result was parked earlier.
    assign w_fwd_ok    = w_pk_max >= (r_lo_max >> FWD_SHIFT);
    assign w_rev_ok    = r_lo_max >= (w_pk_max >> REV_SHIFT);
    assign w_energy_ok = (r_lo_max >= min_energy) && (w_pk_max >= min_energy);

    always_comb begin
        w_code = NO_DIGIT;
        if (!r_lo_tie && !w_pk_tie && w_energy_ok && w_fwd_ok && w_rev_ok) begin
            if (ASCII_MAP != 0) w_code = dtmf_ascii({r_lo_idx[1:0], w_pk_idx[1:0]});
            else                w_code = {1'b0, r_lo_idx, 1'b0, w_pk_idx};
        end
    end

    assign w_is_quiet = (r_code == NO_DIGIT);
    assign w_run_next = (r_code != r_last) ? RUN_W'(1)
                      : (r_run == '1)      ? r_run
                      :                      r_run + RUN_W'(1);
    assign w_emit     = (r_state == ST_DEBOUNCE) && !w_is_quiet && r_seen_quiet
                        && (32'(w_run_next) == DIGIT_FRAMES);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:     if (frame_start) w_next = ST_SCAN_LO;
            ST_SCAN_LO:  if (w_scan_last) w_next = ST_SCAN_HI;
            ST_SCAN_HI:  if (w_scan_last) w_next = ST_CHECK;
            ST_CHECK:    w_next = ST_DEBOUNCE;
            ST_DEBOUNCE: w_next = w_emit ? ST_EMIT : ST_IDLE;
            ST_EMIT:     w_next = ST_IDLE;
            default:     w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt        <= '0;
            r_lo_max     <= '0;
            r_lo_idx     <= '0;
            r_lo_tie     <= 1'b0;
            r_code       <= NO_DIGIT;
            r_last       <= NO_DIGIT;
            r_run        <= '0;
            r_seen_quiet <= 1'b1;
        end else begin
            if (w_scan_en) r_cnt <= w_scan_last ? '0 : r_cnt + IDX_W'(1);
            if ((r_state == ST_SCAN_HI) && (r_cnt == '0)) begin
                r_lo_max <= w_pk_max;
                r_lo_idx <= w_pk_idx;
                r_lo_tie <= w_pk_tie;
            end
            if (r_state == ST_CHECK) r_code <= w_code;
            if (r_state == ST_DEBOUNCE) begin
                r_last <= r_code;
                r_run  <= w_run_next;
                if (w_is_quiet && (32'(w_run_next) >= QUIET_FRAMES)) r_seen_quiet <= 1'b1;
                if (w_emit) r_seen_quiet <= 1'b0;
            end
        end
    end

    // Output port: a pending unaccepted digit makes a new emit drop rather than overwrite.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
            r_valid   <= 1'b0;
            r_dcode   <= NO_DIGIT;
            r_flag    <= 1'b1;
            r_dropped <= 1'b0;
        end else begin
            r_busy    <= (w_next != ST_IDLE);
            r_overrun <= frame_start && (r_state != ST_IDLE);
            r_dropped <= 1'b0;
            if (r_valid && digit_ready) r_valid <= 1'b0;
            if (r_state == ST_EMIT) begin
                if (r_valid && !digit_ready) begin
                    r_dropped <= 1'b1;
                end else begin
                    r_valid <= 1'b1;
                    r_dcode <= r_code;
                    r_flag  <= ~r_flag;
                end
            end
        end
    end

    assign busy          = r_busy;
    assign frame_overrun = r_overrun;
    assign digit_valid   = r_valid;
    assign digit_code    = r_dcode;
    assign dout_flag     = r_flag;
    assign digit_dropped = r_dropped;

endmodule

// File: tb/tb_rcc_tone_classifier.sv
// Scoreboard bench for rcc_tone_classifier: a frame-level model predicts each digit,
// expected codes are queued at stimulus time and popped at each handshake.
`timescale 1ns/1ps
module tb_rcc_tone_classifier;

    localparam int unsigned MAG_W = 16;
    typedef logic [3:0][MAG_W-1:0] mags_t;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             wr_en = 1'b0;
    logic [3:0]       wr_addr = '0;
    logic [MAG_W-1:0] wr_data = '0;
    logic [MAG_W-1:0] min_energy = 16'd100;
    logic             frame_start = 1'b0;
    logic             busy;
    logic             frame_overrun;
    logic             digit_valid;
    logic             digit_ready = 1'b1;
    logic [7:0]       digit_code;
    logic             dout_flag;
    logic             digit_dropped;

    always #5 clk = ~clk;

    rcc_tone_classifier #(
        .N_LOW(4), .N_HIGH(4), .MAG_W(MAG_W), .FWD_SHIFT(2), .REV_SHIFT(2),
        .DIGIT_FRAMES(2), .QUIET_FRAMES(1), .ASCII_MAP(1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .min_energy    (min_energy),
        .frame_start   (frame_start),
        .busy          (busy),
        .frame_overrun (frame_overrun),
        .digit_valid   (digit_valid),
        .digit_ready   (digit_ready),
        .digit_code    (digit_code),
        .dout_flag     (dout_flag),
        .digit_dropped (digit_dropped)
    );

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] sb_q [$];
    logic [7:0] mon_exp;
    int         drop_cnt = 0;
    int         ovr_cnt = 0;

    logic [7:0] m_last = 8'hff;
    int         m_run = 0;
    bit         m_quiet = 1'b1;
    logic       m_flag = 1'b1;
    bit         m_pend = 1'b0;
    int         m_drop_exp = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Handshake monitor: every accepted digit must match the head of the scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            if (digit_valid && digit_ready) begin
                if (sb_q.size() == 0) begin
                    check_eq("spurious_digit", 32'(digit_code), 32'hff);
                end else begin
                    mon_exp = sb_q.pop_front();
                    check_eq("digit_code", 32'(digit_code), 32'(mon_exp));
                end
            end
            if (digit_dropped) drop_cnt++;
            if (frame_overrun) ovr_cnt++;
        end
    end

    function automatic void find_peak(input mags_t m, output logic [MAG_W-1:0] mx,
                                      output int ix, output bit tie);
        int n = 0;
        mx = '0;
        for (int i = 0; i < 4; i++) if (m[i] > mx) mx = m[i];
        ix = -1;
        for (int i = 0; i < 4; i++) begin
            if (m[i] == mx) begin
                n++;
                if (ix < 0) ix = i;
            end
        end
        tie = (n > 1);
    endfunction

    function automatic logic [7:0] model_code(input mags_t lo, input mags_t hi,
                                              input logic [MAG_W-1:0] me);
        string            tbl = "123A456B789C*0#D";
        logic [MAG_W-1:0] lm, hm;
        int               li, hix;
        bit               lt, ht;
        find_peak(lo, lm, li, lt);
        find_peak(hi, hm, hix, ht);
        if (lt || ht) return 8'hff;
        if (lm < me || hm < me) return 8'hff;
        if (hm < (lm >> 2) || lm < (hm >> 2)) return 8'hff;
        return tbl[li * 4 + hix];
    endfunction

    task automatic model_frame(input logic [7:0] code, output bit emit);
        if (code == m_last) begin
            if (m_run < 15) m_run++;
        end else begin
            m_last = code;
            m_run  = 1;
        end
        emit = 1'b0;
        if (code == 8'hff) begin
            if (m_run >= 1) m_quiet = 1'b1;
        end else if (m_run == 2 && m_quiet) begin
            emit    = 1'b1;
            m_quiet = 1'b0;
        end
    endtask

    task automatic write_bank(input mags_t lo, input mags_t hi);
        wr_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_addr = 4'(i);     wr_data = lo[i]; @(posedge clk); #1;
            wr_addr = 4'(8 + i); wr_data = hi[i]; @(posedge clk); #1;
        end
        // Unmapped addresses must leave both banks untouched.
        wr_addr = 4'd5;  wr_data = '1; @(posedge clk); #1;
        wr_addr = 4'd13; wr_data = '1; @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic run_frame(input string name, input mags_t lo, input mags_t hi, input int ovr_at);
        logic [7:0] code;
        bit         emit, exp_seen, seen;
        int         lat;
        logic       prev;
        write_bank(lo, hi);
        code = model_code(lo, hi, min_energy);
        model_frame(code, emit);
        exp_seen = 1'b0;
        if (emit) begin
            if (m_pend && !digit_ready) begin
                m_drop_exp++;
            end else begin
                m_flag   = ~m_flag;
                exp_seen = 1'b1;
                if (digit_ready) sb_q.push_back(code);
                else             m_pend = 1'b1;
            end
        end
        frame_start = 1'b1; @(posedge clk); #1; frame_start = 1'b0;
        seen = 1'b0;
        lat  = 0;
        for (int k = 1; k <= 30; k++) begin
            prev = digit_valid;
            if (ovr_at != 0 && k == ovr_at) frame_start = 1'b1;
            @(posedge clk); #1;
            frame_start = 1'b0;
            if (ovr_at != 0 && k == ovr_at) check_eq({name, "_overrun"}, 32'(frame_overrun), 32'd1);
            if (!prev && digit_valid && !seen) begin
                seen = 1'b1;
                lat  = k;
            end
            if (!busy) break;
        end
        check_eq({name, "_busy_done"}, 32'(busy), 32'd0);
        check_eq({name, "_emit"}, 32'(seen), 32'(exp_seen));
        if (exp_seen) check_eq({name, "_latency"}, 32'(lat), 32'd11);
        check_eq({name, "_flag"}, 32'(dout_flag), 32'(m_flag));
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string name);
        check_eq({name, "_busy"},    32'(busy),          32'd0);
        check_eq({name, "_ovr"},     32'(frame_overrun), 32'd0);
        check_eq({name, "_valid"},   32'(digit_valid),   32'd0);
        check_eq({name, "_code"},    32'(digit_code),    32'hff);
        check_eq({name, "_flag"},    32'(dout_flag),     32'd1);
        check_eq({name, "_dropped"}, 32'(digit_dropped), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        mags_t z, d3_lo, d3_hi, tw_lo, tw249, tw250, tie_lo, a_lo, a_hi, e99_lo, e100_lo;
        mags_t one_lo, one_hi, five_lo, five_hi, nine_lo, nine_hi;
        z       = '0;
        d3_lo   = {16'd10, 16'd10, 16'd10, 16'd900};
        d3_hi   = {16'd10, 16'd800, 16'd10, 16'd10};
        tw_lo   = {16'd10, 16'd10, 16'd10, 16'd1000};
        tw249   = {16'd10, 16'd10, 16'd249, 16'd10};
        tw250   = {16'd10, 16'd10, 16'd250, 16'd10};
        tie_lo  = {16'd0, 16'd0, 16'd500, 16'd500};
        a_lo    = {16'd0, 16'd0, 16'd0, 16'd500};
        a_hi    = {16'd600, 16'd0, 16'd0, 16'd0};
        e99_lo  = {16'd0, 16'd0, 16'd0, 16'd99};
        e100_lo = {16'd0, 16'd0, 16'd0, 16'd100};
        one_lo  = {16'd0, 16'd0, 16'd0, 16'd700};
        one_hi  = {16'd0, 16'd0, 16'd0, 16'd700};
        five_lo = {16'd0, 16'd0, 16'd700, 16'd0};
        five_hi = {16'd0, 16'd0, 16'd700, 16'd0};
        nine_lo = {16'd0, 16'd700, 16'd0, 16'd0};
        nine_hi = {16'd0, 16'd700, 16'd0, 16'd0};

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b1;
        @(posedge clk); #1;

        run_frame("d3_f1", d3_lo, d3_hi, 0);
        run_frame("d3_f2", d3_lo, d3_hi, 0);
        for (int i = 0; i < 5; i++) run_frame("d3_hold", d3_lo, d3_hi, 0);
        run_frame("quiet1", z, z, 0);
        run_frame("d3_r1", d3_lo, d3_hi, 0);
        run_frame("d3_r2", d3_lo, d3_hi, 0);

        run_frame("tw249", tw_lo, tw249, 0);
        run_frame("tw250a", tw_lo, tw250, 0);
        run_frame("tw250b", tw_lo, tw250, 0);

        run_frame("tie", tie_lo, a_hi, 0);
        run_frame("a1", a_lo, a_hi, 0);
        run_frame("a2", a_lo, a_hi, 0);

        run_frame("e99", e99_lo, {16'd120, 16'd0, 16'd0, 16'd0}, 0);
        run_frame("e100a", e100_lo, {16'd120, 16'd0, 16'd0, 16'd0}, 0);
        run_frame("e100b", e100_lo, {16'd120, 16'd0, 16'd0, 16'd0}, 0);

        digit_ready = 1'b0;
        run_frame("quiet2", z, z, 0);
        run_frame("one_a", one_lo, one_hi, 0);
        run_frame("one_b", one_lo, one_hi, 0);
        run_frame("quiet3", z, z, 0);
        run_frame("five_a", five_lo, five_hi, 0);
        run_frame("five_b", five_lo, five_hi, 0);
        check_eq("held_code", 32'(digit_code), 32'h31);
        check_eq("held_valid", 32'(digit_valid), 32'd1);
        check_eq("drop_count", 32'(drop_cnt), 32'(m_drop_exp));
        sb_q.push_back(8'h31);
        m_pend = 1'b0;
        digit_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_eq("released_valid", 32'(digit_valid), 32'd0);

        run_frame("quiet4", z, z, 0);
        run_frame("nine_a", nine_lo, nine_hi, 0);
        run_frame("nine_b", nine_lo, nine_hi, 3);
        check_eq("overrun_count", 32'(ovr_cnt), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check_eq("no_extra_frame", 32'(busy), 32'd0);

        write_bank(d3_lo, d3_hi);
        frame_start = 1'b1; @(posedge clk); #1; frame_start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check_eq("midframe_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(posedge clk); #1;
        reset   = 1'b1;
        m_last  = 8'hff;
        m_run   = 0;
        m_quiet = 1'b1;
        m_flag  = 1'b1;
        m_pend  = 1'b0;
        @(posedge clk); #1;
        run_frame("post_a", d3_lo, d3_hi, 0);
        run_frame("post_b", d3_lo, d3_hi, 0);

        repeat (3) @(posedge clk);
        #1;
        check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
